mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 18, the mainMemory address width.
REQ-002 The block SHALL have parameter DATA_W, default 24, the mainMemory data width.
REQ-003 The block SHALL have parameter MAX_BURST, default 8, the maximum consecutive grants to one owner while the other requester waits (range 1..255).

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset; synchronous and active-high.
REQ-006 The block SHALL have ports req_a and req_b, input, 1 bit each: access request from requester A (CPU) and requester B (DMA).
REQ-007 The block SHALL have ports we_a and we_b, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports addr_a and addr_b, input, ADDR_W bits each: access address.
REQ-009 The block SHALL have ports wdata_a and wdata_b, input, DATA_W bits each: write data.
REQ-010 The block SHALL have ports gnt_a and gnt_b, output, 1 bit each: access accepted this cycle.
REQ-011 The block SHALL have ports rvalid_a and rvalid_b, output, 1 bit each: read data valid.
REQ-012 The block SHALL have ports rdata_a and rdata_b, output, DATA_W bits each: read data.
REQ-013 The block SHALL have port mem_address, output, ADDR_W bits: drives mainMemory address_a.
REQ-014 The block SHALL have port mem_data, output, DATA_W bits: drives mainMemory data_a.
REQ-015 The block SHALL have port mem_wren, output, 1 bit: drives mainMemory wren_a.
REQ-016 The block SHALL have port mem_q, input, DATA_W bits: driven by mainMemory q_a, which is clocked on !clk.

Function
REQ-017 The FSM SHALL have exactly three states (IDLE, OWN_A, OWN_B), an 8-bit burst counter burst_cnt and a round-robin pointer rr (0 = A next, 1 = B next).
REQ-018 gnt_a/gnt_b SHALL be combinational from state, burst_cnt and the req inputs; at most one SHALL be 1 in any cycle.
REQ-019 When any req is high and rst is low, exactly one grant SHALL be issued that cycle (work-conserving).
REQ-020 In IDLE, a single requester SHALL be granted; if both request, the grant SHALL go to the side selected by rr.
REQ-021 In OWN_x, the grant SHALL go to x if req_x=1 and (burst_cnt < MAX_BURST or req_other=0).
REQ-022 In OWN_x, the grant SHALL go to the other side if req_other=1 and either req_x=0 or burst_cnt = MAX_BURST.
REQ-023 In OWN_x with no requests, no grant SHALL be issued and the next state SHALL be IDLE.
REQ-024 A grant to the current owner SHALL increment burst_cnt, saturating at MAX_BURST.
REQ-025 A grant that changes owner SHALL set the state to OWN_granted, set burst_cnt to 1 and set rr to point at the non-granted side.
REQ-026 In a grant cycle, mem_address/mem_data/mem_wren SHALL carry the granted side's addr/wdata/we.
REQ-027 With no grant, mem_wren SHALL be 0, and mem_address/mem_data SHALL hold their last driven values.
REQ-028 For a granted read in cycle N, rdata_x SHALL register mem_q at the end of cycle N, and rvalid_x SHALL be 1 for exactly cycle N+1 (1-cycle latency).
REQ-029 For a granted write, rvalid SHALL NOT be asserted.
REQ-030 rdata_x SHALL hold its value until the next read for side x.
REQ-031 Back-to-back grants to the same side SHALL be allowed every cycle.
REQ-032 A write to address X in cycle N followed by a read of X in cycle N+1 SHALL return the written value.
REQ-033 A requester SHALL hold req/we/addr/wdata stable until it sees gnt; the arbiter SHALL NOT queue requests.

Reset
REQ-034 While rst=1, the block SHALL force gnt_a=gnt_b=0 and mem_wren=0.
REQ-035 After the rst edge: state=IDLE, burst_cnt=0, rr=0, rvalid_a=rvalid_b=0, rdata_a=rdata_b=0, mem_address=0, mem_data=0.
REQ-036 rst asserted in the cycle after a read grant SHALL suppress that read's rvalid.

Verification
REQ-037 Write/readback: A writes 255 to addr 0, then reads addr 0 -> gnt_a each cycle; rvalid_a=1 with rdata_a=255 one cycle after the read grant.
REQ-038 Dual writes: A writes 3444 to addr 200000 and B writes 65535 to addr 10 in the same cycle, from IDLE after reset -> A granted first, B the next cycle; later reads return 3444 and 65535.
REQ-039 Fairness: A and B both request continuously with MAX_BURST=8 -> grants are 8×A, 8×B, alternating indefinitely; never two gnt in one cycle.
REQ-040 Release: B is the owner with burst_cnt=3 and drops req while A requests -> gnt_a the same cycle, state OWN_A, burst_cnt=1.
REQ-041 Idle: no requests -> mem_wren=0 and no rvalid for 10 cycles; a later single req_b read of addr 10 -> gnt_b immediately and rdata_b=65535.
REQ-042 Mid-operation reset: rst asserted in the cycle after A's read grant -> rvalid_a stays 0, mem_wren=0, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (A = CPU, B = DMA) in front of one mainMemory port.
// Burst-limited round-robin grants; read data returns one cycle after the grant.
module mem_port_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 24,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  state_t            r_state, w_nextState;
  logic [7:0]        r_burstCnt, w_nextBurstCnt;
  logic              r_rr, w_nextRr;
  logic              w_gntA, w_gntB;
  logic              w_burstDone;
  logic [ADDR_W-1:0] r_lastAddr;
  logic [DATA_W-1:0] r_lastData;
  logic              r_rvalidA, r_rvalidB;
  logic [DATA_W-1:0] r_rdataA, r_rdataB;

  assign w_burstDone = (r_burstCnt >= MAX_CNT);

  // The owner keeps the port until its burst is spent while the other side waits.
  always_comb begin
    w_gntA         = 1'b0;
    w_gntB         = 1'b0;
    w_nextState    = r_state;
    w_nextBurstCnt = r_burstCnt;
    w_nextRr       = r_rr;

    case (r_state)
      OWN_A: begin
        if (req_a && (!w_burstDone || !req_b)) w_gntA = 1'b1;
        else if (req_b)                        w_gntB = 1'b1;
      end
      OWN_B: begin
        if (req_b && (!w_burstDone || !req_a)) w_gntB = 1'b1;
        else if (req_a)                        w_gntA = 1'b1;
      end
      default: begin
        if (req_a && (!req_b || !r_rr)) w_gntA = 1'b1;
        else if (req_b)                 w_gntB = 1'b1;
      end
    endcase

    if (rst) begin
      w_gntA = 1'b0;
      w_gntB = 1'b0;
    end

    if (w_gntA) begin
      if (r_state == OWN_A) begin
        w_nextBurstCnt = w_burstDone ? MAX_CNT : r_burstCnt + 8'd1;
      end else begin
        w_nextState    = OWN_A;
        w_nextBurstCnt = 8'd1;
        w_nextRr       = 1'b1;
      end
    end else if (w_gntB) begin
      if (r_state == OWN_B) begin
        w_nextBurstCnt = w_burstDone ? MAX_CNT : r_burstCnt + 8'd1;
      end else begin
        w_nextState    = OWN_B;
        w_nextBurstCnt = 8'd1;
        w_nextRr       = 1'b0;
      end
    end else begin
      w_nextState = IDLE;
    end
  end

  assign gnt_a       = w_gntA;
  assign gnt_b       = w_gntB;
  assign mem_wren    = (w_gntA & we_a) | (w_gntB & we_b);
  assign mem_address = w_gntA ? addr_a  : (w_gntB ? addr_b  : r_lastAddr);
  assign mem_data    = w_gntA ? wdata_a : (w_gntB ? wdata_b : r_lastData);

  // Gating with rst drops a read response that would land in a reset cycle.
  assign rvalid_a = r_rvalidA & ~rst;
  assign rvalid_b = r_rvalidB & ~rst;
  assign rdata_a  = r_rdataA;
  assign rdata_b  = r_rdataB;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_burstCnt <= 8'd0;
      r_rr       <= 1'b0;
      r_lastAddr <= '0;
      r_lastData <= '0;
      r_rvalidA  <= 1'b0;
      r_rvalidB  <= 1'b0;
      r_rdataA   <= '0;
      r_rdataB   <= '0;
    end else begin
      r_state    <= w_nextState;
      r_burstCnt <= w_nextBurstCnt;
      r_rr       <= w_nextRr;
      r_lastAddr <= mem_address;
      r_lastData <= mem_data;
      r_rvalidA  <= w_gntA & ~we_a;
      r_rvalidB  <= w_gntB & ~we_b;
      // mem_q was sampled on the falling edge of the grant cycle
      if (w_gntA && !we_a) r_rdataA <= mem_q;
      if (w_gntB && !we_b) r_rdataB <= mem_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a rule-level arbitration/memory model
// predicts grants and read data; a separate monitor matches read responses.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 24;
  localparam int MAX_BURST = 8;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_a = 1'b0, req_b = 1'b0;
  logic              we_a = 1'b0, we_b = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
  logic              gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wren;
  logic [DATA_W-1:0] rdata_a, rdata_b, mem_data;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_q = '0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // mainMemory stand-in: single port clocked on the falling edge
  logic [DATA_W-1:0] memArr [int];
  always @(negedge clk) begin
    if (mem_wren) memArr[int'(mem_address)] = mem_data;
    if (memArr.exists(int'(mem_address))) mem_q <= memArr[int'(mem_address)];
    else mem_q <= '0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nPass   = 0;

  // reference model: last owner, its run length, tie-break side, memory contents
  int                refOwner = 0;
  int                refRun   = 0;
  int                refNext  = 1;
  logic [ADDR_W-1:0] refLastAddr = '0;
  logic [DATA_W-1:0] refLastData = '0;
  logic [DATA_W-1:0] refMem [int];
  exp_t              expA[$];
  exp_t              expB[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic failNow(input string name);
    nChecks++;
    $display("[TB] FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic txn_t mk(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
    txn_t t;
    t.req = r; t.we = w; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic logic [ADDR_W-1:0] pickAddr();
    case ($urandom_range(0, 5))
      0: return 18'd0;
      1: return 18'd10;
      2: return 18'd200000;
      3: return 18'd262143;
      4: return 18'd5;
      default: return 18'd77;
    endcase
  endfunction

  // Drive one cycle, predict the grant from the arbitration rules and compare.
  task automatic applyStimulus(input txn_t a, input txn_t b, input logic r, output int g);
    txn_t w;
    exp_t e;
    @(posedge clk); #1;
    rst = r;
    req_a = a.req; we_a = a.we; addr_a = a.addr; wdata_a = a.data;
    req_b = b.req; we_b = b.we; addr_b = b.addr; wdata_b = b.data;
    #2;
    g = 0;
    if (!r && (a.req || b.req)) begin
      if (a.req && !b.req)           g = 1;
      else if (b.req && !a.req)      g = 2;
      else if (refOwner == 0)        g = refNext;
      else if (refRun >= MAX_BURST)  g = 3 - refOwner;
      else                           g = refOwner;
    end
    w = (g == 2) ? b : a;
    checkOutput("gnt_a", gnt_a, g == 1);
    checkOutput("gnt_b", gnt_b, g == 2);
    checkOutput("mem_wren", mem_wren, (g != 0) && w.we);
    checkOutput("mem_address", mem_address, (g != 0) ? w.addr : refLastAddr);
    checkOutput("mem_data", mem_data, (g != 0) ? w.data : refLastData);
    if (r) begin
      refOwner = 0; refRun = 0; refNext = 1;
      refLastAddr = '0; refLastData = '0;
    end else if (g != 0) begin
      if (g == refOwner) refRun = (refRun < MAX_BURST) ? refRun + 1 : MAX_BURST;
      else begin
        refOwner = g; refRun = 1; refNext = 3 - g;
      end
      refLastAddr = w.addr;
      refLastData = w.data;
      if (w.we) refMem[int'(w.addr)] = w.data;
      else begin
        e.data = refMem.exists(int'(w.addr)) ? refMem[int'(w.addr)] : '0;
        e.due  = cyc + 1;
        if (g == 1) expA.push_back(e);
        else        expB.push_back(e);
      end
    end else begin
      refOwner = 0;
    end
  endtask

  // Monitor: pops expected read responses as rvalid appears
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        while (expA.size() > 0 && expA[0].due <= cyc) void'(expA.pop_front());
        while (expB.size() > 0 && expB[0].due <= cyc) void'(expB.pop_front());
        checkOutput("rvalid_a in reset", rvalid_a, 1'b0);
        checkOutput("rvalid_b in reset", rvalid_b, 1'b0);
      end else begin
        if (rvalid_a) begin
          if (expA.size() == 0) failNow("rvalid_a unexpected");
          else begin
            e = expA.pop_front();
            checkOutput("rdata_a", rdata_a, e.data);
            checkOutput("rvalid_a cycle", cyc, e.due);
          end
        end else if (expA.size() > 0 && expA[0].due <= cyc) begin
          failNow("rvalid_a missing");
          void'(expA.pop_front());
        end
        if (rvalid_b) begin
          if (expB.size() == 0) failNow("rvalid_b unexpected");
          else begin
            e = expB.pop_front();
            checkOutput("rdata_b", rdata_b, e.data);
            checkOutput("rvalid_b cycle", cyc, e.due);
          end
        end else if (expB.size() > 0 && expB[0].due <= cyc) begin
          failNow("rvalid_b missing");
          void'(expB.pop_front());
        end
      end
    end
  end

  initial begin
    txn_t none, pa, pb;
    int   g;
    none = mk(1'b0, 1'b0, '0, '0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(none, none, 1'b1, g);
    applyStimulus(none, none, 1'b0, g);
    checkOutput("rdata_a after reset", rdata_a, '0);
    checkOutput("rdata_b after reset", rdata_b, '0);

    $display("[TB] write/readback");
    applyStimulus(mk(1'b1, 1'b1, 18'd0, 24'd255), none, 1'b0, g);
    applyStimulus(mk(1'b1, 1'b0, 18'd0, 24'd0), none, 1'b0, g);
    applyStimulus(none, none, 1'b0, g);
    checkOutput("readback rvalid_a", rvalid_a, 1'b1);
    checkOutput("readback rdata_a", rdata_a, 24'd255);

    $display("[TB] dual writes");
    applyStimulus(none, none, 1'b1, g);
    applyStimulus(mk(1'b1, 1'b1, 18'd200000, 24'd3444), mk(1'b1, 1'b1, 18'd10, 24'd65535), 1'b0, g);
    checkOutput("dual first gnt_a", gnt_a, 1'b1);
    applyStimulus(none, mk(1'b1, 1'b1, 18'd10, 24'd65535), 1'b0, g);
    checkOutput("dual second gnt_b", gnt_b, 1'b1);
    applyStimulus(mk(1'b1, 1'b0, 18'd200000, '0), mk(1'b1, 1'b0, 18'd10, '0), 1'b0, g);
    applyStimulus(mk(1'b1, 1'b0, 18'd200000, '0), none, 1'b0, g);
    applyStimulus(none, none, 1'b0, g);
    checkOutput("dual read rdata_a", rdata_a, 24'd3444);
    checkOutput("dual read rdata_b", rdata_b, 24'd65535);

    $display("[TB] idle then single B read");
    repeat (10) applyStimulus(none, none, 1'b0, g);
    applyStimulus(none, mk(1'b1, 1'b0, 18'd10, '0), 1'b0, g);
    checkOutput("idle gnt_b", gnt_b, 1'b1);
    applyStimulus(none, none, 1'b0, g);
    checkOutput("idle rdata_b", rdata_b, 24'd65535);

    $display("[TB] fairness");
    applyStimulus(none, none, 1'b1, g);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(mk(1'b1, 1'b0, 18'd0, '0), mk(1'b1, 1'b0, 18'd10, '0), 1'b0, g);
      checkOutput("fair gnt_a", gnt_a, ((i / MAX_BURST) % 2) == 0);
    end

    $display("[TB] release");
    applyStimulus(none, none, 1'b1, g);
    repeat (3) applyStimulus(none, mk(1'b1, 1'b0, 18'd10, '0), 1'b0, g);
    applyStimulus(mk(1'b1, 1'b0, 18'd0, '0), none, 1'b0, g);
    checkOutput("release gnt_a", gnt_a, 1'b1);
    applyStimulus(mk(1'b1, 1'b0, 18'd0, '0), mk(1'b1, 1'b0, 18'd10, '0), 1'b0, g);
    checkOutput("release owner keeps", gnt_a, 1'b1);

    $display("[TB] mid-operation reset");
    applyStimulus(none, none, 1'b0, g);
    applyStimulus(mk(1'b1, 1'b0, 18'd0, '0), none, 1'b0, g);
    applyStimulus(none, none, 1'b1, g);
    checkOutput("midreset rvalid_a", rvalid_a, 1'b0);
    applyStimulus(mk(1'b1, 1'b0, 18'd10, '0), mk(1'b1, 1'b0, 18'd0, '0), 1'b0, g);
    checkOutput("midreset idle tie gnt_a", gnt_a, 1'b1);
    applyStimulus(none, mk(1'b1, 1'b0, 18'd0, '0), 1'b0, g);

    $display("[TB] random traffic");
    pa = none;
    pb = none;
    for (int i = 0; i < 500; i++) begin
      if (!pa.req && $urandom_range(0, 99) < 60)
        pa = mk(1'b1, 1'($urandom_range(0, 1)), pickAddr(), DATA_W'($urandom));
      if (!pb.req && $urandom_range(0, 99) < 60)
        pb = mk(1'b1, 1'($urandom_range(0, 1)), pickAddr(), DATA_W'($urandom));
      applyStimulus(pa, pb, 1'b0, g);
      if (g == 1) pa.req = 1'b0;
      if (g == 2) pb.req = 1'b0;
    end

    repeat (3) applyStimulus(none, none, 1'b0, g);
    checkOutput("expA drained", expA.size(), 0);
    checkOutput("expB drained", expB.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
